// File: rtl/end_screen_ctrl.sv
// end_screen_ctrl: game-over sequencer for the goose-run game.
// It freezes play on a collision and then shows the GAME OVER overlay.
// It waits for an armed restart press and then pulses game_rst.
// Ports:
//   clk, reset (async, active-high)
//   frame_tick, collide, btn_restart
//   freeze, show_end, overlay_on, game_rst, state[1:0]
// Optional blink: define END_BLINK_EN to blink overlay_on in OVER.
module end_screen_ctrl #(
   parameter int unsigned FREEZE_FRAMES = 30,
   parameter int unsigned ARM_FRAMES    = 15,
   parameter int unsigned BLINK_FRAMES  = 20,
   parameter int unsigned RST_CYCLES    = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       frame_tick,
   input  logic       collide,
   input  logic       btn_restart,
   output logic       freeze,
   output logic       show_end,
   output logic       overlay_on,
   output logic       game_rst,
   output logic [1:0] state
);

   typedef enum logic [1:0] {
      S_PLAY    = 2'd0,
      S_FREEZE  = 2'd1,
      S_OVER    = 2'd2,
      S_RESTART = 2'd3
   } state_t;

   localparam logic [7:0] FRZ_LAST = 8'(FREEZE_FRAMES - 1);
   localparam logic [7:0] ARM_LAST = 8'(ARM_FRAMES);
   localparam logic [7:0] RST_LAST = 8'(RST_CYCLES - 1);

   state_t     state_q, state_d;
   logic [7:0] cnt_q, cnt_d;
   logic       btn_q, btn_d;
   logic       freeze_q, freeze_d;
   logic       show_end_q, show_end_d;
   logic       overlay_on_q, overlay_on_d;
   logic       game_rst_q, game_rst_d;
   logic       armed;
   logic       btn_edge;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= S_PLAY;
         cnt_q        <= 8'd0;
         btn_q        <= 1'b0;
         freeze_q     <= 1'b0;
         show_end_q   <= 1'b0;
         overlay_on_q <= 1'b0;
         game_rst_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         btn_q        <= btn_d;
         freeze_q     <= freeze_d;
         show_end_q   <= show_end_d;
         overlay_on_q <= overlay_on_d;
         game_rst_q   <= game_rst_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      btn_d    = btn_restart;
      btn_edge = btn_restart & ~btn_q;
      // armed uses the pre-update count, so an edge coinciding with the
      // arming tick is rejected.
      armed    = (cnt_q == ARM_LAST);
      unique case (state_q)
         S_PLAY: begin
            if (collide) begin
               state_d = S_FREEZE;
               cnt_d   = 8'd0;
            end
         end
         S_FREEZE: begin
            if (frame_tick) begin
               if (cnt_q == FRZ_LAST) begin
                  state_d = S_OVER;
                  cnt_d   = 8'd0;
               end else begin
                  cnt_d = cnt_q + 8'd1;
               end
            end
         end
         S_OVER: begin
            if (btn_edge && armed) begin
               state_d = S_RESTART;
               cnt_d   = 8'd0;
            end else if (frame_tick && !armed) begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         S_RESTART: begin
            if (cnt_q == RST_LAST) begin
               state_d = S_PLAY;
               cnt_d   = 8'd0;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
      endcase
      freeze_d   = (state_d != S_PLAY);
      show_end_d = (state_d == S_OVER);
      game_rst_d = (state_d == S_RESTART);
   end

`ifdef END_BLINK_EN
   logic [7:0] blink_cnt_q, blink_cnt_d;
   logic       phase_q, phase_d;

   localparam logic [7:0] BLK_LAST = 8'(BLINK_FRAMES - 1);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         blink_cnt_q <= 8'd0;
         phase_q     <= 1'b1;
      end else begin
         blink_cnt_q <= blink_cnt_d;
         phase_q     <= phase_d;
      end
   end

   always_comb begin
      blink_cnt_d = blink_cnt_q;
      phase_d     = phase_q;
      if (state_q != S_OVER && state_d == S_OVER) begin
         blink_cnt_d = 8'd0;
         phase_d     = 1'b1;
      end else if (state_q == S_OVER && frame_tick) begin
         if (blink_cnt_q == BLK_LAST) begin
            blink_cnt_d = 8'd0;
            phase_d     = ~phase_q;
         end else begin
            blink_cnt_d = blink_cnt_q + 8'd1;
         end
      end
      overlay_on_d = show_end_d & phase_d;
   end
`else
   always_comb begin
      overlay_on_d = show_end_d;
   end
`endif

   assign freeze     = freeze_q;
   assign show_end   = show_end_q;
   assign overlay_on = overlay_on_q;
   assign game_rst   = game_rst_q;
   assign state      = state_q;

endmodule
